pipe_smpy: RTL and testbench



---
 rtl/fft_mpy_pkg.sv | 10 +
 rtl/bimpy.sv | 20 ++
 rtl/pipe_smpy.sv | 109 ++++++++++
 tb/tb_pipe_smpy.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fft_mpy_pkg.sv
// fft_mpy_pkg: digit width and slice/latency helpers shared by the FFT multipliers
package fft_mpy_pkg;
    localparam int LUTB = 2;
    function automatic int ns_of(input int iaw);
        return (iaw + LUTB - 1) / LUTB;
    endfunction
    function automatic int lat_of(input int iaw);
        return ns_of(iaw) + 2;
    endfunction
endpackage

// File: rtl/bimpy.sv
// bimpy: registered unsigned LUTB x BW partial-product slice
module bimpy
    import fft_mpy_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clk_enable,
    input  logic [LUTB-1:0]      i_a,
    input  logic [BW-1:0]        i_b,
    output logic [BW+LUTB-1:0]   o_r
);
    // Digit times operand, held when the pipe is stalled
    always_ff @(posedge i_clk)
        if (i_reset)
            o_r <= '0;
        else if (i_clk_enable)
            o_r <= (BW+LUTB)'(i_a) * (BW+LUTB)'(i_b);
endmodule

// File: rtl/pipe_smpy.sv
// pipe_smpy: pipelined signed multiplier from bimpy digit slices; PIPE_SMPY_AUX_EN adds an aligned i_aux/o_aux strobe
module pipe_smpy
    import fft_mpy_pkg::*;
#(
    parameter int IAW = 16,
    parameter int IBW = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_clk_enable,
`ifdef PIPE_SMPY_AUX_EN
    input  logic                       i_aux,
`endif
    input  logic [IAW-1:0]             i_a,
    input  logic [IBW-1:0]             i_b,
`ifdef PIPE_SMPY_AUX_EN
    output logic                       o_aux,
`endif
    output logic signed [IAW+IBW-1:0]  o_r
);
    localparam int NS  = ns_of(IAW);
    localparam int OW  = IAW + IBW;
    localparam int LAT = lat_of(IAW);
    localparam int MW  = LUTB * NS;

    logic [MW-1:0]  r_ma [0:NS-1];
    logic [IBW-1:0] r_mb [0:NS-1];
    logic           r_s  [0:NS];
    logic [OW-1:0]  w_p   [0:NS-1];
    logic [OW-1:0]  w_acc [0:NS-1];
    logic [IAW-1:0] w_ma;
    logic [IBW-1:0] w_mb;
    logic [OW-1:0]  w_sum;

    if (IAW > IBW) begin : g_bad_widths
        $error("pipe_smpy: IAW must not exceed IBW");
    end

    // The most-negative input negates to 2^(W-1), which still fits W bits unsigned
    assign w_ma = i_a[IAW-1] ? -i_a : i_a;
    assign w_mb = i_b[IBW-1] ? -i_b : i_b;

    // Stage 0 magnitudes and sign, then delay lines keeping them beside each digit slice
    always_ff @(posedge i_clk)
        if (i_reset) begin
            for (int i = 0; i < NS; i++) begin
                r_ma[i] <= '0;
                r_mb[i] <= '0;
            end
            for (int i = 0; i <= NS; i++)
                r_s[i] <= 1'b0;
        end else if (i_clk_enable) begin
            r_ma[0] <= MW'(w_ma);
            r_mb[0] <= w_mb;
            r_s[0]  <= i_a[IAW-1] ^ i_b[IBW-1];
            for (int i = 1; i < NS; i++) begin
                r_ma[i] <= r_ma[i-1];
                r_mb[i] <= r_mb[i-1];
            end
            for (int i = 1; i <= NS; i++)
                r_s[i] <= r_s[i-1];
        end

    for (genvar j = 0; j < NS; j++) begin : g_s
        logic [IBW+LUTB-1:0] w_bp;
        bimpy #(.BW(IBW)) u_bimpy (
            .i_clk        (i_clk),
            .i_reset      (i_reset),
            .i_clk_enable (i_clk_enable),
            .i_a          (r_ma[j][LUTB*j +: LUTB]),
            .i_b          (r_mb[j]),
            .o_r          (w_bp)
        );
        assign w_p[j] = OW'(w_bp) << (LUTB * j);
        if (j == 0) begin : g_z
            assign w_acc[0] = '0;
        end else begin : g_a
            localparam int AW = (IBW + LUTB*j < OW) ? IBW + LUTB*j : OW;
            logic [AW-1:0] r_acc;
            // Running sum of the digit products already out of their slices
            always_ff @(posedge i_clk)
                if (i_reset)
                    r_acc <= '0;
                else if (i_clk_enable)
                    r_acc <= AW'(w_acc[j-1] + w_p[j-1]);
            assign w_acc[j] = OW'(r_acc);
        end
    end

    assign w_sum = w_acc[NS-1] + w_p[NS-1];

    // Restore the sign; a zero magnitude negates to zero
    always_ff @(posedge i_clk)
        if (i_reset)
            o_r <= '0;
        else if (i_clk_enable)
            o_r <= r_s[NS] ? -w_sum : w_sum;

`ifdef PIPE_SMPY_AUX_EN
    logic [LAT-1:0] r_aux;
    // Side strobe delayed to leave alongside its product
    always_ff @(posedge i_clk)
        if (i_reset)
            r_aux <= '0;
        else if (i_clk_enable)
            r_aux <= {r_aux[LAT-2:0], i_aux};
    assign o_aux = r_aux[LAT-1];
`endif
endmodule

// File: tb/tb_pipe_smpy.sv
// tb_pipe_smpy: directed and random checks of pipe_smpy at 16x16 and 7x12 against a product-queue model
module tb_pipe_smpy;
    localparam int LAT1 = 10;
    localparam int LAT2 = 6;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic en_i = 1'b0;
    logic aux_i = 1'b0;
    logic signed [15:0] a_i = '0;
    logic signed [15:0] b_i = '0;
    logic signed [6:0]  a2;
    logic signed [11:0] b2;
    logic signed [31:0] o_r1;
    logic signed [18:0] o_r2;
    logic o_aux1, o_aux2;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 0;

    assign a2 = a_i[6:0];
    assign b2 = b_i[11:0];

    always #5 clk = ~clk;

    pipe_smpy #(.IAW(16), .IBW(16)) u_dut1 (
        .i_clk        (clk),
        .i_reset      (rst_i),
        .i_clk_enable (en_i),
`ifdef PIPE_SMPY_AUX_EN
        .i_aux        (aux_i),
        .o_aux        (o_aux1),
`endif
        .i_a          (a_i),
        .i_b          (b_i),
        .o_r          (o_r1)
    );

    pipe_smpy #(.IAW(7), .IBW(12)) u_dut2 (
        .i_clk        (clk),
        .i_reset      (rst_i),
        .i_clk_enable (en_i),
`ifdef PIPE_SMPY_AUX_EN
        .i_aux        (aux_i),
        .o_aux        (o_aux2),
`endif
        .i_a          (a2),
        .i_b          (b2),
        .o_r          (o_r2)
    );

`ifndef PIPE_SMPY_AUX_EN
    assign o_aux1 = 1'b0;
    assign o_aux2 = 1'b0;
`endif

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each accepted pair's product comes out LAT accepted edges later
    longint q1[$], q2[$];
    bit qa1[$], qa2[$];
    longint e1 = 0, e2 = 0;
    bit ea1 = 0, ea2 = 0;

    always @(posedge clk) begin
        if (rst_i) begin
            q1 = {}; q2 = {}; qa1 = {}; qa2 = {};
            for (int i = 0; i < LAT1 - 1; i++) begin q1.push_back(0); qa1.push_back(0); end
            for (int i = 0; i < LAT2 - 1; i++) begin q2.push_back(0); qa2.push_back(0); end
            e1 = 0; e2 = 0; ea1 = 0; ea2 = 0;
        end else if (en_i) begin
            q1.push_back(longint'(a_i) * longint'(b_i));
            q2.push_back(longint'(a2) * longint'(b2));
            qa1.push_back(aux_i);
            qa2.push_back(aux_i);
            e1 = q1.pop_front();
            e2 = q2.pop_front();
            ea1 = qa1.pop_front();
            ea2 = qa2.pop_front();
        end
    end

    always @(negedge clk)
        if (chk_on) begin
            chk("model_16x16", o_r1, e1);
            chk("model_7x12", o_r2, e2);
`ifdef PIPE_SMPY_AUX_EN
            chk("model_aux16", o_aux1, ea1);
            chk("model_aux7", o_aux2, ea2);
`endif
        end

    task automatic cyc(input int a, input int b, input logic en, input logic rs, input logic ax);
        a_i = 16'(a);
        b_i = 16'(b);
        en_i = en;
        rst_i = rs;
        aux_i = ax;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e, m;
        logic signed [31:0] hv;
        logic ha;
        for (int c = 0; c < 20; c++) begin
            cyc(0, 0, 1, 1, 1);
            chk_on = 1;
            chk("reset_zero", o_r1, 0);
`ifdef PIPE_SMPY_AUX_EN
            chk("reset_aux", o_aux1, 0);
`endif
        end
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) cyc(3, 5, 1, 0, 0);
            else cyc(0, 0, 1, 0, 0);
            chk("pair_3x5", o_r1, (k == 10) ? 15 : 0);
        end
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) cyc(-32768, -32768, 1, 0, 0);
            else if (k == 2) cyc(-32768, 32767, 1, 0, 0);
            else cyc(0, 0, 1, 0, 0);
            if (k == 10) chk("neg_x_neg", o_r1, 64'sh40000000);
            if (k == 11) chk("neg_x_pos", o_r1, -64'sd1073709056);
        end
        e = 0; hv = 0; ha = 0;
        for (int c = 0; c < 32; c++) begin
            logic en;
            int k;
            en = !((c >= 4 && c < 7) || (c >= 20 && c % 3 == 0));
            if (en) begin
                k = e + 1;
                cyc(k <= 12 ? k : 0, k <= 12 ? -k : 0, 1, 0, (k <= 12) && k[0]);
                e++;
                m = e - 9;
                hv = (m >= 1 && m <= 12) ? -(m * m) : 0;
                ha = (m >= 1 && m <= 12) && m[0];
            end else
                cyc(77, -77, 0, 0, 1);
            chk("gap_stream", o_r1, hv);
`ifdef PIPE_SMPY_AUX_EN
            chk("gap_aux", o_aux1, ha);
`endif
        end
        for (int k = 1; k <= 12; k++) cyc(k, 7, 1, 0, 0);
        chk("pre_reset", o_r1, 21);
        cyc(50, 50, 0, 1, 1);
        chk("reset_out", o_r1, 0);
        for (int k = 1; k <= 10; k++) begin
            cyc(k == 1 ? 2 : 5, k == 1 ? -3 : 5, 1, 0, 0);
            chk("post_reset", o_r1, (k == 10) ? -6 : 0);
        end
        repeat (10000)
            cyc(int'($urandom), int'($urandom), $urandom_range(0, 3) != 0, 0, 1'($urandom_range(0, 1)));
        repeat (12) cyc(0, 0, 1, 0, 0);
        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
